// File: rtl/axi_lite_write_arbiter.sv
// Two-requester round-robin front end onto a single AXI4-Lite write channel.
// One transaction is in flight at a time; completions are pulsed back to the granted requester.
module axi_lite_write_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic [1:0]        req_valid,
  input  logic [ADDR_W-1:0] req_addr0,
  input  logic [ADDR_W-1:0] req_addr1,
  input  logic [31:0]       req_data0,
  input  logic [31:0]       req_data1,
  input  logic [3:0]        req_strb0,
  input  logic [3:0]        req_strb1,
  output logic [1:0]        req_ready,
  output logic [1:0]        resp_valid,
  output logic [1:0]        resp,
  output logic              AWVALID,
  input  logic              AWREADY,
  output logic [ADDR_W-1:0] AWADDR,
  output logic              WVALID,
  input  logic              WREADY,
  output logic [31:0]       WDATA,
  output logic [3:0]        WSTRB,
  input  logic              BVALID,
  output logic              BREADY,
  input  logic [1:0]        BRESP,
  output logic              busy,
  output logic [CNT_W-1:0]  wr_count
);

  typedef enum logic [1:0] {IDLE, XFER, RESP, DONE} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         data_q, data_d;
  logic [3:0]          strb_q, strb_d;
  logic                gnt_q, gnt_d;
  logic                last_q, last_d;
  logic                awvalid_q, awvalid_d;
  logic                wvalid_q, wvalid_d;
  logic [1:0]          bresp_q, bresp_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                gnt_sel;

  // Round-robin pick: on a tie the requester not granted last wins.
  always_comb begin
    gnt_sel = 1'b0;
    if (req_valid == 2'b11) gnt_sel = ~last_q;
    else                    gnt_sel = req_valid[1];
  end

  always_ff @(posedge ACLK or posedge ARESETn) begin
    if (ARESETn) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      data_q    <= '0;
      strb_q    <= '0;
      gnt_q     <= 1'b0;
      last_q    <= 1'b1;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bresp_q   <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      strb_q    <= strb_d;
      gnt_q     <= gnt_d;
      last_q    <= last_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bresp_q   <= bresp_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    data_d     = data_q;
    strb_d     = strb_q;
    gnt_d      = gnt_q;
    last_d     = last_q;
    awvalid_d  = awvalid_q;
    wvalid_d   = wvalid_q;
    bresp_d    = bresp_q;
    cnt_d      = cnt_q;
    req_ready  = 2'b00;
    resp_valid = 2'b00;
    resp       = 2'b00;
    case (state_q)
      IDLE: begin
        // Accept is combinational but suppressed while reset is held.
        if ((|req_valid) && !ARESETn) begin
          req_ready[gnt_sel] = 1'b1;
          gnt_d     = gnt_sel;
          addr_d    = gnt_sel ? req_addr1 : req_addr0;
          data_d    = gnt_sel ? req_data1 : req_data0;
          strb_d    = gnt_sel ? req_strb1 : req_strb0;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          state_d   = XFER;
        end
      end
      XFER: begin
        if (awvalid_q && AWREADY) awvalid_d = 1'b0;
        if (wvalid_q && WREADY)   wvalid_d  = 1'b0;
        if ((!awvalid_q || AWREADY) && (!wvalid_q || WREADY)) state_d = RESP;
      end
      RESP: begin
        if (BVALID) begin
          bresp_d = BRESP;
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = DONE;
        end
      end
      DONE: begin
        resp_valid[gnt_q] = 1'b1;
        resp              = bresp_q;
        last_d            = gnt_q;
        state_d           = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign AWVALID  = awvalid_q;
  assign AWADDR   = awvalid_q ? addr_q : '0;
  assign WVALID   = wvalid_q;
  assign WDATA    = wvalid_q ? data_q : '0;
  assign WSTRB    = wvalid_q ? strb_q : '0;
  assign BREADY   = (state_q == RESP);
  assign busy     = (state_q != IDLE);
  assign wr_count = cnt_q;

endmodule

// File: tb/tb_axi_lite_write_arbiter.sv
// Directed bench for axi_lite_write_arbiter with a 2-bit completion counter so wrap is reachable.
module tb_axi_lite_write_arbiter;

  logic        ACLK;
  logic        ARESETn;
  logic [1:0]  req_valid;
  logic [31:0] req_addr0, req_addr1;
  logic [31:0] req_data0, req_data1;
  logic [3:0]  req_strb0, req_strb1;
  logic [1:0]  req_ready, resp_valid, resp;
  logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY, busy;
  logic [31:0] AWADDR, WDATA;
  logic [3:0]  WSTRB;
  logic [1:0]  BRESP;
  logic [1:0]  wr_count;

  int ncmp = 0;
  int nerr = 0;

  axi_lite_write_arbiter #(.ADDR_W(32), .CNT_W(2)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .req_valid(req_valid),
    .req_addr0(req_addr0), .req_addr1(req_addr1),
    .req_data0(req_data0), .req_data1(req_data1),
    .req_strb0(req_strb0), .req_strb1(req_strb1),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp(resp),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR),
    .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
    .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
    .busy(busy), .wr_count(wr_count)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic cyc();
    @(posedge ACLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Full-speed transaction: entered at the accept cycle, returns in the DONE cycle.
  task automatic fast_txn(input string t, input logic [1:0] gnt, input logic [31:0] addr,
                          input logic [31:0] data, input logic [1:0] br, input logic [1:0] cnt);
    chk({t, "_req_ready"}, req_ready, gnt);
    cyc(); #1;
    chk({t, "_awaddr"}, AWADDR, addr);
    chk({t, "_wdata"}, WDATA, data);
    chk({t, "_req_ready_xfer"}, req_ready, 2'b00);
    cyc(); BVALID = 1'b1; BRESP = br; #1;
    chk({t, "_bready"}, BREADY, 1'b1);
    cyc(); BVALID = 1'b0; #1;
    chk({t, "_resp_valid"}, resp_valid, gnt);
    chk({t, "_resp"}, resp, br);
    chk({t, "_wr_count"}, wr_count, cnt);
  endtask

  initial begin
    ARESETn = 1'b1; req_valid = 2'b00;
    req_addr0 = '0; req_addr1 = '0; req_data0 = '0; req_data1 = '0;
    req_strb0 = '0; req_strb1 = '0;
    AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b0; BRESP = 2'b00;
    repeat (2) cyc();
    req_valid = 2'b11; #1;
    chk("rst_req_ready", req_ready, 2'b00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_awvalid", AWVALID, 1'b0);
    chk("rst_wvalid", WVALID, 1'b0);
    chk("rst_bready", BREADY, 1'b0);
    chk("rst_awaddr", AWADDR, 32'h0);
    chk("rst_wr_count", wr_count, 2'd0);
    chk("rst_resp_valid", resp_valid, 2'b00);

    // Single write with zero-wait slave
    cyc(); ARESETn = 1'b0; req_valid = 2'b01;
    req_addr0 = 32'h10; req_data0 = 32'hA5A5_A5A5; req_strb0 = 4'hF;
    AWREADY = 1'b1; WREADY = 1'b1; #1;
    chk("single_req_ready", req_ready, 2'b01);
    chk("single_busy_idle", busy, 1'b0);
    cyc(); req_valid = 2'b00; #1;
    chk("single_awvalid", AWVALID, 1'b1);
    chk("single_awaddr", AWADDR, 32'h10);
    chk("single_wvalid", WVALID, 1'b1);
    chk("single_wdata", WDATA, 32'hA5A5_A5A5);
    chk("single_wstrb", WSTRB, 4'hF);
    chk("single_busy", busy, 1'b1);
    chk("single_bready_xfer", BREADY, 1'b0);
    cyc(); BVALID = 1'b1; BRESP = 2'b00; #1;
    chk("single_awvalid_drop", AWVALID, 1'b0);
    chk("single_wvalid_drop", WVALID, 1'b0);
    chk("single_awaddr_zero", AWADDR, 32'h0);
    chk("single_wdata_zero", WDATA, 32'h0);
    chk("single_bready", BREADY, 1'b1);
    cyc(); BVALID = 1'b0; #1;
    chk("single_resp_valid", resp_valid, 2'b01);
    chk("single_resp", resp, 2'b00);
    chk("single_wr_count", wr_count, 2'd1);
    chk("single_bready_done", BREADY, 1'b0);
    cyc(); #1;
    chk("single_resp_valid_clr", resp_valid, 2'b00);
    chk("single_busy_end", busy, 1'b0);

    // Tie arbitration from a fresh reset, then two lone requests that wrap the 2-bit counter
    cyc(); ARESETn = 1'b1; req_valid = 2'b11;
    req_addr0 = 32'h100; req_data0 = 32'h1111_1111; req_strb0 = 4'h3;
    req_addr1 = 32'h200; req_data1 = 32'h2222_2222; req_strb1 = 4'hC; #1;
    chk("tie_rst_wr_count", wr_count, 2'd0);
    cyc(); ARESETn = 1'b0; #1;
    fast_txn("tie0", 2'b01, 32'h100, 32'h1111_1111, 2'b00, 2'd1);
    cyc(); #1;
    fast_txn("tie1", 2'b10, 32'h200, 32'h2222_2222, 2'b00, 2'd2);
    cyc(); #1;
    fast_txn("tie2", 2'b01, 32'h100, 32'h1111_1111, 2'b00, 2'd3);
    cyc(); req_valid = 2'b10; #1;
    fast_txn("wrap0", 2'b10, 32'h200, 32'h2222_2222, 2'b00, 2'd0);
    cyc(); req_valid = 2'b01; #1;
    fast_txn("wrap1", 2'b01, 32'h100, 32'h1111_1111, 2'b00, 2'd1);

    // Split handshake: AW accepted at N+1, W accepted at N+4
    cyc(); req_valid = 2'b10; AWREADY = 1'b0; WREADY = 1'b0; #1;
    chk("split_req_ready", req_ready, 2'b10);
    cyc(); req_valid = 2'b00; AWREADY = 1'b1; #1;
    chk("split_awvalid_n1", AWVALID, 1'b1);
    chk("split_wvalid_n1", WVALID, 1'b1);
    chk("split_awaddr_n1", AWADDR, 32'h200);
    cyc(); AWREADY = 1'b0; #1;
    chk("split_awvalid_n2", AWVALID, 1'b0);
    chk("split_awaddr_n2", AWADDR, 32'h0);
    chk("split_wvalid_n2", WVALID, 1'b1);
    chk("split_wdata_n2", WDATA, 32'h2222_2222);
    chk("split_wstrb_n2", WSTRB, 4'hC);
    chk("split_bready_n2", BREADY, 1'b0);
    cyc(); #1;
    chk("split_wvalid_n3", WVALID, 1'b1);
    chk("split_awvalid_n3", AWVALID, 1'b0);
    cyc(); WREADY = 1'b1; #1;
    chk("split_wvalid_n4", WVALID, 1'b1);
    chk("split_bready_n4", BREADY, 1'b0);
    cyc(); WREADY = 1'b0; BVALID = 1'b1; BRESP = 2'b01; #1;
    chk("split_wvalid_n5", WVALID, 1'b0);
    chk("split_wdata_n5", WDATA, 32'h0);
    chk("split_bready_n5", BREADY, 1'b1);
    cyc(); BVALID = 1'b0; #1;
    chk("split_resp_valid", resp_valid, 2'b10);
    chk("split_resp", resp, 2'b01);
    chk("split_wr_count", wr_count, 2'd2);

    // Error response with BVALID held off for five RESP cycles
    cyc(); req_valid = 2'b01; AWREADY = 1'b1; WREADY = 1'b1; #1;
    chk("err_req_ready", req_ready, 2'b01);
    cyc(); req_valid = 2'b00; #1;
    chk("err_awvalid", AWVALID, 1'b1);
    for (int i = 0; i < 5; i++) begin
      cyc(); #1;
      chk("err_bready_wait", BREADY, 1'b1);
      chk("err_resp_valid_wait", resp_valid, 2'b00);
    end
    cyc(); BVALID = 1'b1; BRESP = 2'b10; #1;
    chk("err_bready", BREADY, 1'b1);
    cyc(); BVALID = 1'b0; #1;
    chk("err_resp_valid", resp_valid, 2'b01);
    chk("err_resp", resp, 2'b10);
    chk("err_wr_count", wr_count, 2'd3);

    // Reset while AWVALID is up aborts the write and restores the tie pointer
    cyc(); req_valid = 2'b01; AWREADY = 1'b0; WREADY = 1'b0; #1;
    chk("abort_req_ready", req_ready, 2'b01);
    cyc(); req_valid = 2'b11; #1;
    chk("abort_awvalid_pre", AWVALID, 1'b1);
    ARESETn = 1'b1; BVALID = 1'b1; #1;
    chk("abort_awvalid", AWVALID, 1'b0);
    chk("abort_wvalid", WVALID, 1'b0);
    chk("abort_awaddr", AWADDR, 32'h0);
    chk("abort_wdata", WDATA, 32'h0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_bready", BREADY, 1'b0);
    chk("abort_wr_count", wr_count, 2'd0);
    chk("abort_req_ready_rst", req_ready, 2'b00);
    chk("abort_resp_valid", resp_valid, 2'b00);
    cyc(); ARESETn = 1'b0; BVALID = 1'b0; AWREADY = 1'b1; WREADY = 1'b1; #1;
    chk("abort_resp_valid_post", resp_valid, 2'b00);
    fast_txn("post_rst", 2'b01, 32'h100, 32'h1111_1111, 2'b00, 2'd1);
    cyc(); req_valid = 2'b00; #1;
    chk("post_rst_idle", busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
